// File: rtl/uart_pkt_xcvr_if.sv
// User-side bundle of the UART packet transceiver: TX request/data, RX data and status pulses.
// The serial pins and clock/reset stay plain ports on the transceiver.
interface uart_pkt_xcvr_if #(
    parameter int NBYTES = 3
);
    localparam int W = 8 * NBYTES;

    logic         uart_tx_req;
    logic [W-1:0] idats;
    logic         uart_txs_done;
    logic         tx_busy;
    logic         uart_rxs_done;
    logic [W-1:0] odats;
    logic         rx_err;

    modport master (
        output uart_tx_req, idats,
        input  uart_txs_done, tx_busy, uart_rxs_done, odats, rx_err
    );

    modport slave (
        input  uart_tx_req, idats,
        output uart_txs_done, tx_busy, uart_rxs_done, odats, rx_err
    );
endinterface

// File: rtl/uart_pkt_xcvr.sv
// Full-duplex UART packet transceiver: NBYTES frames per packet, MSB byte first, LSB bit first.
// Define UART_PARITY_EN to insert/check a parity bit (PARITY_ODD selects odd sense) after d7.
module uart_pkt_xcvr #(
    parameter int NBYTES     = 3,
    parameter int BAUD_DIV   = 434,
    parameter int RX_TIMEOUT = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    uart_pkt_xcvr_if.slave   bus,
    output logic             uarttx,
    input  logic             uartrx
);
    localparam int W       = 8 * NBYTES;
    localparam int CNT_W   = $clog2(BAUD_DIV);
    localparam int IDX_W   = $clog2(NBYTES + 1);
    localparam int TMO_LIM = RX_TIMEOUT * BAUD_DIV;
    localparam int TMO_W   = $clog2(TMO_LIM + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(NBYTES - 1);
    localparam logic [TMO_W-1:0] TMO_HIT   = TMO_W'(TMO_LIM);

    if (NBYTES < 1 || NBYTES > 16 || BAUD_DIV < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_pkt_xcvr: parameter out of range");
    end

`ifdef UART_PARITY_EN
    function automatic logic parity_bit(input logic [7:0] b);
        return (^b) ^ (PARITY_ODD != 0);
    endfunction
`endif

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PAR,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PAR,
`endif
        RX_STOP
    } rx_state_t;

    tx_state_t        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [IDX_W-1:0] tx_byte;
    logic [W-1:0]     tx_pkt;
    logic [7:0]       tx_cur;
    logic             tx_bit_end;
    logic             tx_done;

    assign tx_cur     = tx_pkt[W-1 -: 8];
    assign tx_bit_end = (tx_cnt == BIT_LAST);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_n;
    end

    always_comb begin
        tx_state_n = tx_state;
        uarttx     = 1'b1;
        tx_done    = 1'b0;
        case (tx_state)
            TX_IDLE:  if (bus.uart_tx_req) tx_state_n = TX_START;
            TX_START: begin
                uarttx = 1'b0;
                if (tx_bit_end) tx_state_n = TX_DATA;
            end
            TX_DATA: begin
                uarttx = tx_cur[tx_bit];
                if (tx_bit_end && tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                    tx_state_n = TX_PAR;
`else
                    tx_state_n = TX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            TX_PAR: begin
                uarttx = parity_bit(tx_cur);
                if (tx_bit_end) tx_state_n = TX_STOP;
            end
`endif
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_byte == BYTE_LAST) begin
                        tx_done    = 1'b1;
                        tx_state_n = TX_IDLE;
                    end else begin
                        tx_state_n = TX_START;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n || tx_state == TX_IDLE) begin
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
        end else begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
            if (tx_state == TX_DATA && tx_bit_end) tx_bit <= tx_bit + 1'b1;
            if (tx_state == TX_STOP && tx_bit_end) tx_byte <= tx_byte + 1'b1;
        end
    end

    // Packet shifts left a byte per frame so the byte on air is always the top one.
    always_ff @(posedge sys_clk) begin
        if (tx_state == TX_IDLE && bus.uart_tx_req) tx_pkt <= bus.idats;
        else if (tx_state == TX_STOP && tx_bit_end) tx_pkt <= tx_pkt << 8;
    end

    assign bus.uart_txs_done = tx_done;
    assign bus.tx_busy       = (tx_state != TX_IDLE) && !tx_done;

    // ---- RX: 2-flop synchroniser plus one delay flop for falling-edge detection
    logic rx_sync_p0, rx_sync_p1, rx_sync_p2;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_sync_p2 <= 1'b1;
        end else begin
            rx_sync_p0 <= uartrx;
            rx_sync_p1 <= rx_sync_p0;
            rx_sync_p2 <= rx_sync_p1;
        end
    end

    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_byte;
    logic [IDX_W-1:0] rx_idx;
    logic [TMO_W-1:0] rx_tmo_cnt;
    logic [W-1:0]     rx_asm, rx_asm_n, rx_odats;
    logic             rx_bitv, rx_fall, rx_bit_end, rx_tmo;
    logic             rx_byte_ok, rx_bad, rx_done, rx_err;

    assign rx_bitv    = rx_sync_p1;
    assign rx_fall    = rx_sync_p2 & ~rx_sync_p1;
    assign rx_bit_end = (rx_cnt == BIT_LAST);
    assign rx_tmo     = (rx_state == RX_IDLE) && (rx_idx != '0) && (rx_tmo_cnt == TMO_HIT);
    assign rx_asm_n   = (rx_asm << 8) | W'(rx_byte);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_state_n;
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_byte_ok = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_state_n = rx_bitv ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_bit_end && rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                    rx_state_n = RX_PAR;
`else
                    rx_state_n = RX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            RX_PAR: begin
                if (rx_bit_end) begin
                    if (rx_bitv != parity_bit(rx_byte)) begin
                        rx_bad     = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_STOP;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_state_n = RX_IDLE;
                    rx_byte_ok = rx_bitv;
                    rx_bad     = ~rx_bitv;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rx_cnt <= '0;
            rx_bit <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_state_n != rx_state || rx_bit_end) rx_cnt <= '0;
            else rx_cnt <= rx_cnt + 1'b1;
            if (rx_state != RX_DATA) rx_bit <= '0;
            else if (rx_bit_end)     rx_bit <= rx_bit + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rx_state == RX_DATA && rx_bit_end) rx_byte <= {rx_bitv, rx_byte[7:1]};
        if (rx_byte_ok) rx_asm <= rx_asm_n;
    end

    // Stale assembly bytes are harmless: exactly NBYTES fresh bytes are shifted in before a copy.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rx_idx     <= '0;
            rx_tmo_cnt <= '0;
            rx_done    <= 1'b0;
            rx_err     <= 1'b0;
            rx_odats   <= '0;
        end else begin
            rx_done    <= 1'b0;
            rx_err     <= rx_bad | rx_tmo;
            rx_tmo_cnt <= (rx_state == RX_IDLE && rx_idx != '0 && !rx_tmo) ? rx_tmo_cnt + 1'b1 : '0;
            if (rx_bad || rx_tmo) begin
                rx_idx <= '0;
            end else if (rx_byte_ok) begin
                if (rx_idx == BYTE_LAST) begin
                    rx_idx   <= '0;
                    rx_odats <= rx_asm_n;
                    rx_done  <= 1'b1;
                end else begin
                    rx_idx <= rx_idx + 1'b1;
                end
            end
        end
    end

    assign bus.uart_rxs_done = rx_done;
    assign bus.odats         = rx_odats;
    assign bus.rx_err        = rx_err;
endmodule
